// File: rtl/snake_draw_ctrl.sv
// Snake game draw controller: holds the segment list, runs the move FSM and
// streams one pixel per cycle (x, y, plot, vga_colour) to a VGA adapter.
module snake_draw_ctrl #(
    parameter int MAXLEN  = 8,
    parameter int SEG     = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int X0      = 80,
    parameter int Y0      = 60
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] dir,
    input  logic       grow,
    input  logic [2:0] colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic [2:0] vga_colour,
    output logic       busy,
    output logic [3:0] length,
    output logic       dead,
    output logic [2:0] state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ERASE = 3'd3;
    localparam logic [2:0] MOVE  = 3'd4;
    localparam logic [2:0] DRAW  = 3'd5;
    localparam logic [2:0] DEAD  = 3'd6;

    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int CW = (SEG > 1) ? $clog2(SEG) : 1;
    localparam logic [CW-1:0] SEG_LAST = CW'(SEG - 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    seg_x_q [MAXLEN];
    logic [7:0]    seg_x_d [MAXLEN];
    logic [6:0]    seg_y_q [MAXLEN];
    logic [6:0]    seg_y_d [MAXLEN];
    logic [3:0]    len_q, len_d;
    logic [1:0]    cur_dir_q, cur_dir_d, move_dir_q, move_dir_d, pend_dir_q, pend_dir_d;
    logic          pend_tick_q, pend_tick_d, pend_grow_q, pend_grow_d;
    logic [CW-1:0] xc_q, xc_d, yc_q, yc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    x_hold_q, x_hold_d;
    logic [6:0]    y_hold_q, y_hold_d;
    logic [2:0]    col_hold_q, col_hold_d;

    logic          scanning, last_pix, wait_hit, move_hit;
    logic [IW-1:0] sel;
    logic [7:0]    scan_x, next_x;
    logic [6:0]    scan_y, next_y;
    logic [2:0]    scan_col;
    logic [1:0]    req_dir, wait_dir;

    // Checked before any subtraction so a move off the top/left never wraps.
    function automatic logic hits_wall(input logic [7:0] hx, input logic [6:0] hy,
                                       input logic [1:0] d);
        logic hit;
        case (d)
            2'b00:   hit = ({1'b0, hx} + 9'(SEG)) > 9'(XSCREEN - SEG);
            2'b01:   hit = ({1'b0, hy} + 8'(SEG)) > 8'(YSCREEN - SEG);
            2'b10:   hit = hy < 7'(SEG);
            default: hit = hx < 8'(SEG);
        endcase
        return hit;
    endfunction

    assign scanning = (state_q == INIT) || (state_q == ERASE) || (state_q == DRAW);
    assign last_pix = (xc_q == SEG_LAST) && (yc_q == SEG_LAST);

    always_comb begin
        sel = '0;
        case (state_q)
            INIT:    sel = idx_q;
            ERASE:   sel = IW'(len_q - 4'd1);
            default: sel = '0;
        endcase
    end

    assign scan_x   = seg_x_q[sel] + 8'(xc_q);
    assign scan_y   = seg_y_q[sel] + 7'(yc_q);
    assign scan_col = (state_q == ERASE) ? 3'b000 : colour;

    // Direction is resolved once when the step leaves WAIT; a reversal keeps cur_dir.
    assign req_dir  = pend_tick_q ? pend_dir_q : dir;
    assign wait_dir = (req_dir == ~cur_dir_q) ? cur_dir_q : req_dir;
    assign wait_hit = hits_wall(seg_x_q[0], seg_y_q[0], wait_dir);
    assign move_hit = hits_wall(seg_x_q[0], seg_y_q[0], move_dir_q);

    always_comb begin
        next_x = seg_x_q[0];
        next_y = seg_y_q[0];
        case (move_dir_q)
            2'b00:   next_x = seg_x_q[0] + 8'(SEG);
            2'b01:   next_y = seg_y_q[0] + 7'(SEG);
            2'b10:   next_y = seg_y_q[0] - 7'(SEG);
            default: next_x = seg_x_q[0] - 8'(SEG);
        endcase
    end

    assign x          = scanning ? scan_x : x_hold_q;
    assign y          = scanning ? scan_y : y_hold_q;
    assign vga_colour = scanning ? scan_col : col_hold_q;
    assign plot       = scanning;
    assign busy       = !((state_q == IDLE) || (state_q == WAIT) || (state_q == DEAD));
    assign dead       = (state_q == DEAD);
    assign length     = len_q;
    assign state_o    = state_q;

    always_comb begin
        state_d     = state_q;
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        len_d       = len_q;
        cur_dir_d   = cur_dir_q;
        move_dir_d  = move_dir_q;
        pend_dir_d  = pend_dir_q;
        pend_tick_d = pend_tick_q;
        pend_grow_d = pend_grow_q | grow;
        xc_d        = xc_q;
        yc_d        = yc_q;
        idx_d       = idx_q;
        x_hold_d    = scanning ? scan_x : x_hold_q;
        y_hold_d    = scanning ? scan_y : y_hold_q;
        col_hold_d  = scanning ? scan_col : col_hold_q;

        if (busy && tick && !pend_tick_q) begin
            pend_tick_d = 1'b1;
            pend_dir_d  = dir;
        end

        if (scanning) begin
            if (xc_q == SEG_LAST) begin
                xc_d = '0;
                yc_d = last_pix ? '0 : yc_q + 1'b1;
            end else begin
                xc_d = xc_q + 1'b1;
            end
        end

        case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    for (int i = 0; i < MAXLEN; i++) begin
                        seg_x_d[i] = (i < 3) ? 8'(X0 - SEG * i) : 8'd0;
                        seg_y_d[i] = (i < 3) ? 7'(Y0) : 7'd0;
                    end
                    len_d     = 4'd3;
                    cur_dir_d = 2'b00;
                    idx_d     = '0;
                    xc_d      = '0;
                    yc_d      = '0;
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (last_pix) begin
                    if (4'(idx_q) == len_q - 4'd1) begin
                        idx_d   = '0;
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (tick || pend_tick_q) begin
                    pend_tick_d = 1'b0;
                    move_dir_d  = wait_dir;
                    // A growing or fatal step leaves the tail square untouched.
                    state_d     = (pend_grow_q || wait_hit) ? MOVE : ERASE;
                end
            end
            ERASE: begin
                if (last_pix) state_d = MOVE;
            end
            MOVE: begin
                if (move_hit) begin
                    state_d = DEAD;
                end else begin
                    for (int i = 1; i < MAXLEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = next_x;
                    seg_y_d[0] = next_y;
                    cur_dir_d  = move_dir_q;
                    if (pend_grow_q) begin
                        pend_grow_d = grow;
                        if (len_q < 4'(MAXLEN)) len_d = len_q + 4'd1;
                    end
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (last_pix) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            for (int i = 0; i < MAXLEN; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
            len_q       <= '0;
            cur_dir_q   <= '0;
            move_dir_q  <= '0;
            pend_dir_q  <= '0;
            pend_tick_q <= 1'b0;
            pend_grow_q <= 1'b0;
            xc_q        <= '0;
            yc_q        <= '0;
            idx_q       <= '0;
            x_hold_q    <= '0;
            y_hold_q    <= '0;
            col_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            len_q       <= len_d;
            cur_dir_q   <= cur_dir_d;
            move_dir_q  <= move_dir_d;
            pend_dir_q  <= pend_dir_d;
            pend_tick_q <= pend_tick_d;
            pend_grow_q <= pend_grow_d;
            xc_q        <= xc_d;
            yc_q        <= yc_d;
            idx_q       <= idx_d;
            x_hold_q    <= x_hold_d;
            y_hold_q    <= y_hold_d;
            col_hold_q  <= col_hold_d;
        end
    end

endmodule

// File: tb/tb_snake_draw_ctrl.sv
// Bench for snake_draw_ctrl: directed scenarios plus a random walk, checked
// against a queue-based snake model that predicts every plotted pixel.
module tb_snake_draw_ctrl;

    localparam int MAXLEN = 8;
    localparam int SEG    = 10;
    localparam int XS     = 160;
    localparam int YS     = 120;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       tick     = 1'b0;
    logic [1:0] dir      = 2'b00;
    logic       grow     = 1'b0;
    logic [2:0] colour   = 3'b010;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic [2:0] vga_colour;
    logic       busy;
    logic [3:0] length;
    logic       dead;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int mx[$];
    int my[$];
    int m_dir;
    bit m_grow;
    bit m_dead;

    snake_draw_ctrl dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start), .tick(tick), .dir(dir),
        .grow(grow), .colour(colour), .x(x), .y(y), .plot(plot),
        .vga_colour(vga_colour), .busy(busy), .length(length), .dead(dead),
        .state_o(state_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (plot) got_q.push_back({x, y, vga_colour});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input int c);
        return {8'(px), 7'(py), 3'(c)};
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0:       return 3;
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_square(input int sx, input int sy, input int c);
        for (int r = 0; r < SEG; r++)
            for (int col = 0; col < SEG; col++)
                exp_q.push_back(pix(sx + col, sy + r, c));
    endtask

    task automatic model_start(input int c);
        mx = {80, 70, 60};
        my = {60, 60, 60};
        m_dir  = 0;
        m_dead = 0;
        for (int i = 0; i < 3; i++) model_square(mx[i], my[i], c);
    endtask

    task automatic model_step(input int d, input int c, output int cyc);
        int nd, nx, ny;
        nd = (d == opposite(m_dir)) ? m_dir : d;
        nx = mx[0];
        ny = my[0];
        case (nd)
            0:       nx = nx + SEG;
            1:       ny = ny + SEG;
            2:       ny = ny - SEG;
            default: nx = nx - SEG;
        endcase
        if (nx < 0 || ny < 0 || nx > XS - SEG || ny > YS - SEG) begin
            m_dead = 1;
            cyc = 2;
            return;
        end
        m_dir = nd;
        if (m_grow) begin
            m_grow = 0;
            mx.push_front(nx);
            my.push_front(ny);
            if (mx.size() > MAXLEN) begin
                void'(mx.pop_back());
                void'(my.pop_back());
            end
            cyc = 102;
        end else begin
            model_square(mx[mx.size()-1], my[my.size()-1], 0);
            void'(mx.pop_back());
            void'(my.pop_back());
            mx.push_front(nx);
            my.push_front(ny);
            cyc = 202;
        end
        model_square(nx, ny, c);
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 1;
        while (busy && n < limit) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_val("idle_reached", busy, 0);
    endtask

    task automatic compare_plots(input string tag);
        int nbad;
        logic [17:0] last;
        nbad = 0;
        check_val({tag, "_nplots"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
        check_val({tag, "_pixbad"}, nbad, 0);
        if (exp_q.size() > 0) begin
            last = exp_q[exp_q.size()-1];
            check_val({tag, "_xhold"}, x, last[17:10]);
            check_val({tag, "_yhold"}, y, last[9:3]);
        end
    endtask

    function automatic logic [17:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : '1;
    endfunction

    task automatic do_reset();
        Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_plot", plot, 0);
        check_val("rst_x", x, 0);
        check_val("rst_y", y, 0);
        check_val("rst_col", vga_colour, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_dead", dead, 0);
        check_val("rst_len", length, 0);
        Resetn = 1'b1;
        mx.delete();
        my.delete();
        m_grow = 0;
        m_dead = 0;
        m_dir  = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_start(input string tag);
        int n;
        got_q.delete();
        exp_q.delete();
        model_start(int'(colour));
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        wait_idle(1000, n);
        check_val({tag, "_cycles"}, n, 301);
        compare_plots(tag);
        check_val({tag, "_first"}, got_at(0), pix(80, 60, int'(colour)));
        check_val({tag, "_len"}, length, 3);
        check_val({tag, "_dead"}, dead, 0);
    endtask

    task automatic do_step(input logic [1:0] d, input string tag);
        int cyc_exp, n;
        got_q.delete();
        exp_q.delete();
        model_step(int'(d), int'(colour), cyc_exp);
        @(negedge CLOCK_50); tick = 1'b1; dir = d;
        @(negedge CLOCK_50); tick = 1'b0; dir = 2'($urandom_range(0, 3));
        wait_idle(600, n);
        check_val({tag, "_cycles"}, n, cyc_exp);
        compare_plots(tag);
        check_val({tag, "_len"}, length, mx.size());
        check_val({tag, "_dead"}, dead, m_dead);
    endtask

    task automatic pulse_grow();
        @(negedge CLOCK_50); grow = 1'b1;
        @(negedge CLOCK_50); grow = 1'b0;
        m_grow = 1;
    endtask

    initial begin
        int c1, c2;

        do_reset();
        colour = 3'b010;
        do_start("start");
        check_val("start_last", got_at(299), pix(69, 69, 2));

        do_step(2'b00, "right");
        check_val("right_erase0", got_at(0), pix(60, 60, 0));
        check_val("right_head", got_at(199), pix(99, 69, 2));

        // start outside IDLE/DEAD must do nothing
        got_q.delete();
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check_val("start_ignored_plots", got_q.size(), 0);
        check_val("start_ignored_busy", busy, 0);

        do_reset();
        do_start("start2");
        do_step(2'b11, "reverse");
        check_val("reverse_head", got_at(199), pix(99, 69, 2));

        pulse_grow();
        do_step(2'b00, "grow");
        check_val("grow_len4", length, 4);

        do_reset();
        do_start("start3");
        for (int i = 0; i < 7; i++) do_step(2'b00, "run_right");
        do_step(2'b00, "wall");
        check_val("wall_dead", dead, 1);
        check_val("wall_len", length, 3);
        got_q.delete();
        @(negedge CLOCK_50); tick = 1'b1;
        @(negedge CLOCK_50); tick = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check_val("dead_tick_plots", got_q.size(), 0);
        check_val("dead_hold", dead, 1);
        do_start("restart");

        // second tick during DRAW is latched, third is dropped
        got_q.delete();
        exp_q.delete();
        model_step(0, int'(colour), c1);
        model_step(1, int'(colour), c2);
        @(negedge CLOCK_50); tick = 1'b1; dir = 2'b00;
        @(negedge CLOCK_50); tick = 1'b0;
        repeat (150) @(negedge CLOCK_50);
        tick = 1'b1; dir = 2'b01;
        @(negedge CLOCK_50); tick = 1'b0; dir = 2'b11;
        repeat (20) @(negedge CLOCK_50);
        tick = 1'b1; dir = 2'b10;
        @(negedge CLOCK_50); tick = 1'b0;
        repeat (400) @(negedge CLOCK_50);
        check_val("pend_cycles_model", c1 + c2, 404);
        check_val("pend_busy", busy, 0);
        compare_plots("pend");
        check_val("pend_len", length, mx.size());

        for (int it = 0; it < 50; it++) begin
            colour = 3'($urandom_range(1, 7));
            if (m_dead) begin
                do_start("rand_start");
            end else begin
                if ($urandom_range(0, 3) == 0) pulse_grow();
                do_step(2'($urandom_range(0, 3)), "rand_step");
            end
        end

        // reset in the middle of an erase scan
        do_reset();
        colour = 3'b101;
        do_start("start4");
        got_q.delete();
        @(negedge CLOCK_50); tick = 1'b1; dir = 2'b00;
        @(negedge CLOCK_50); tick = 1'b0;
        repeat (49) @(negedge CLOCK_50);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check_val("abort_plot", plot, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_len", length, 0);
        check_val("abort_x", x, 0);
        check_val("abort_dead", dead, 0);
        repeat (3) @(negedge CLOCK_50);
        check_val("abort_nplots", got_q.size(), 50);
        Resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_draw_ctrl.md
SNAKE_DRAW_CTRL -- requirements
Module: snake_draw_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8: maximum number of snake segments.
REQ-002 Parameter SEG, default 10: segment square edge, in pixels.
REQ-003 Parameter XSCREEN, default 160: screen width, in pixels.
REQ-004 Parameter YSCREEN, default 120: screen height, in pixels.
REQ-005 Parameters X0 = 80 and Y0 = 60: initial head position.
REQ-006 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-007 Resetn  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle pulse; loads the initial snake and begins drawing it.
REQ-009 tick  in  1  one-cycle pulse; requests one move step.
REQ-010 dir  in  2  requested direction: 00 right, 01 down, 10 up, 11 left.
REQ-011 grow  in  1  one-cycle pulse; requests one extra segment.
REQ-012 colour  in  3  snake colour.
REQ-013 x  out  8  pixel x coordinate.
REQ-014 y  out  7  pixel y coordinate.
REQ-015 plot  out  1  pixel write strobe.
REQ-016 vga_colour  out  3  pixel colour.
REQ-017 busy  out  1  high in any state except IDLE, WAIT and DEAD.
REQ-018 length  out  4  current segment count.
REQ-019 dead  out  1  high when a wall has been hit.

Function
REQ-020 Segment storage shall be MAXLEN registered (x,y) pairs; index 0 is the head.
REQ-021 The FSM shall have the states IDLE, INIT, WAIT, ERASE, MOVE, DRAW and DEAD.
REQ-022 IDLE: start loads length = 3, segment i = (X0 - SEG*i, Y0), and cur_dir = right, then goes to INIT.
REQ-023 INIT: draw segments 0..length-1 in order, each one as a raster scan, then go to WAIT.
REQ-024 Raster scan: one pixel per cycle, with the inner counter xc = 0..SEG-1 and the outer counter yc = 0..SEG-1.
REQ-025 During a raster scan, x = seg_x + xc, y = seg_y + yc and plot = 1.
REQ-026 WAIT: a tick sends the FSM to ERASE on the next cycle; if a grow is pending it goes to MOVE instead.
REQ-027 A tick arriving while busy shall be latched as a single pending tick; any further ticks while busy are dropped.
REQ-028 The pending tick shall be serviced on the cycle WAIT is entered.
REQ-029 grow shall set a pending-grow flag at any time; the flag clears when it is consumed in MOVE.
REQ-030 ERASE: raster-scan segment length-1 with vga_colour = 000.
REQ-031 MOVE: lasts one cycle with plot = 0, and first resolves the move direction.
REQ-032 MOVE direction: cur_dir takes the dir sampled at the tick, unless that dir is the exact reverse of cur_dir, in which case it is ignored.
REQ-033 MOVE wall check: next head = head ± SEG on one axis.
REQ-034 MOVE shall go to DEAD, with segments and length unchanged, if the next head x > XSCREEN-SEG, or y > YSCREEN-SEG, or the move is left or up from coordinate < SEG. The check is done before subtraction (no wrap).
REQ-035 MOVE update, when the wall check passes: shift segments i <- i-1 and load the new head.
REQ-036 MOVE growth: if grow is pending and length < MAXLEN, length increments; at MAXLEN the grow is consumed with no effect.
REQ-037 DRAW: raster-scan segment 0 with vga_colour = colour, then go to WAIT.
REQ-038 DEAD: hold until Resetn, or until start, which reinitialises as in IDLE.
REQ-039 Outside a scan, plot = 0 and x, y, vga_colour hold their last values.
REQ-040 A start received in any state other than IDLE or DEAD shall be ignored.
REQ-041 A step with no growth takes 2*SEG*SEG+2 cycles from the tick to WAIT: 202 cycles at default parameters.

Reset
REQ-042 While Resetn = 0: state IDLE, plot = 0, x = 0, y = 0, vga_colour = 000, busy = 0, dead = 0, length = 0, all pending flags cleared, segments = 0.
REQ-043 Reset asserted mid-scan shall abort the scan immediately, with no further plots.

Verification
REQ-044 Reset, then start with colour = 010 -> exactly 300 plots; the first is (80,60) and the last is (69,69); length = 3; busy falls.
REQ-045 tick with dir = 00 -> 100 erase plots covering (60..69, 60..69) in colour 000, then 100 plots covering (90..99, 60..69); head = (90,60).
REQ-046 From the initial snake, tick with dir = 11 (reverse) -> snake moves right; head = (90,60).
REQ-047 grow followed by tick -> no erase plots; length = 4; the tail square stays drawn.
REQ-048 Head at (150,60), tick with dir = 00 -> no plots; dead = 1; a later start restarts the snake at (80,60).
REQ-049 A second tick during DRAW, plus a third -> exactly one extra step executes; reset asserted at plot 50 of ERASE -> plot = 0 on the next cycle and state IDLE.
